// File: rtl/usb_phy_pkg.sv
// Shared USB 3.0 PHY definitions: K28.5 comma symbols, word-alignment FSM encoding,
// symbol/counter widths and a saturating counter helper.
package usb_phy_pkg;

   localparam int unsigned SYM_W = 10;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned PH_W  = 4;

   localparam logic [SYM_W-1:0] K28_5_NEG = 10'h17C;
   localparam logic [SYM_W-1:0] K28_5_POS = 10'h283;

   localparam logic [1:0] HUNT    = 2'd0;
   localparam logic [1:0] CONFIRM = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/usb_serialtopar_if.sv
// Receive-side serial/parallel bundle: serial bit in, aligned word with strobes out.
interface usb_serialtopar_if;
   import usb_phy_pkg::*;

   logic             SerialIn;
   logic [SYM_W-1:0] Parout;
   logic             ParValid;
   logic             CommaDet;
   logic             Locked;

   modport master (output SerialIn, input Parout, ParValid, CommaDet, Locked);
   modport slave  (input SerialIn, output Parout, ParValid, CommaDet, Locked);

endinterface

// File: rtl/usb_comma_detect.sv
// Combinational K28.5 comma matcher (either running disparity); shared with the decoder.
module usb_comma_detect
   import usb_phy_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic             match
);

   always_comb begin
      match = (sym == K28_5_NEG) || (sym == K28_5_POS);
   end

endmodule

// File: rtl/usb_serialtopar.sv
// Serial-to-parallel converter with K28.5 word alignment: LSB-first shift-in,
// comma-driven boundary search, lock/loss hysteresis and registered word output.
module usb_serialtopar
   import usb_phy_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 2,
   parameter int unsigned LOSS_COUNT = 4
) (
   input logic              Serialclk,
   input logic              SerialRST,
   usb_serialtopar_if.slave ser
);

   localparam logic [CNT_W-1:0] LOCK_THR = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] LOSS_THR = CNT_W'(LOSS_COUNT);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SYM_W - 1);

   logic [SYM_W-1:0] sh;
   logic [PH_W-1:0]  phase;
   logic [1:0]       state;
   logic [CNT_W-1:0] good_cnt;
   logic [CNT_W-1:0] bad_cnt;
   logic [CNT_W-1:0] good_inc;
   logic [CNT_W-1:0] bad_inc;
   logic             comma_hit;
   logic             boundary;

   usb_comma_detect u_comma (
      .sym   (sh),
      .match (comma_hit)
   );

   always_comb begin
      boundary = (phase == PH_LAST);
      good_inc = sat_inc(good_cnt);
      bad_inc  = sat_inc(bad_cnt);
   end

   always_ff @(posedge Serialclk) begin
      if (SerialRST) begin
         sh           <= '0;
         phase        <= '0;
         state        <= HUNT;
         good_cnt     <= '0;
         bad_cnt      <= '0;
         ser.Parout   <= '0;
         ser.ParValid <= 1'b0;
         ser.CommaDet <= 1'b0;
         ser.Locked   <= 1'b0;
      end else begin
         sh           <= {ser.SerialIn, sh[SYM_W-1:1]};
         phase        <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
         ser.ParValid <= 1'b0;
         ser.CommaDet <= 1'b0;

         case (state)
            HUNT: begin
               if (comma_hit) begin
                  // phase <= 0 makes the current cycle the boundary: next one is 10 cycles on
                  phase        <= '0;
                  good_cnt     <= CNT_W'(1);
                  bad_cnt      <= '0;
                  ser.Parout   <= sh;
                  ser.ParValid <= 1'b1;
                  ser.CommaDet <= 1'b1;
                  if (LOCK_THR == CNT_W'(1)) begin
                     state      <= LOCKED;
                     ser.Locked <= 1'b1;
                  end else begin
                     state <= CONFIRM;
                  end
               end
            end

            CONFIRM: begin
               if (comma_hit && !boundary) begin
                  phase        <= '0;
                  good_cnt     <= CNT_W'(1);
                  ser.Parout   <= sh;
                  ser.ParValid <= 1'b1;
                  ser.CommaDet <= 1'b1;
               end else if (boundary) begin
                  ser.Parout   <= sh;
                  ser.ParValid <= 1'b1;
                  ser.CommaDet <= comma_hit;
                  if (comma_hit) begin
                     good_cnt <= good_inc;
                     if (good_inc == LOCK_THR) begin
                        state      <= LOCKED;
                        ser.Locked <= 1'b1;
                     end
                  end
               end
            end

            LOCKED: begin
               if (boundary) begin
                  ser.Parout   <= sh;
                  ser.ParValid <= 1'b1;
                  ser.CommaDet <= comma_hit;
                  if (comma_hit) begin
                     bad_cnt <= '0;
                  end
               end else if (comma_hit) begin
                  // misaligned comma: count only, the established boundary is kept
                  if (bad_inc == LOSS_THR) begin
                     state      <= HUNT;
                     ser.Locked <= 1'b0;
                     good_cnt   <= '0;
                     bad_cnt    <= '0;
                  end else begin
                     bad_cnt <= bad_inc;
                  end
               end
            end

            default: begin
               state      <= HUNT;
               ser.Locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_serialtopar.sv
// Directed bench for usb_serialtopar: reset, lock acquisition, CONFIRM realign,
// loss of lock, loss-counter clear, serializer-style loopback and reset priority.
module tb_usb_serialtopar;
   import usb_phy_pkg::*;

   logic        Serialclk = 1'b0;
   logic        SerialRST = 1'b1;
   int unsigned cyc       = 0;
   int unsigned n_chk     = 0;
   int unsigned n_pass    = 0;
   int unsigned n_fail    = 0;
   int unsigned last_samp = 0;

   logic [9:0]  ev_word  [$];
   logic        ev_comma [$];
   logic        ev_lock  [$];
   int unsigned ev_cyc   [$];
   int unsigned rise_cyc = 0;
   int unsigned fall_cyc = 0;
   int unsigned fall_cnt = 0;
   logic        lk_prev  = 1'b0;

   logic [9:0]  xw [$];
   logic        xc [$];
   logic        xl [$];

   usb_serialtopar_if bus ();

   usb_serialtopar #(
      .LOCK_COUNT (2),
      .LOSS_COUNT (4)
   ) dut (
      .Serialclk (Serialclk),
      .SerialRST (SerialRST),
      .ser       (bus)
   );

   always #5 Serialclk = ~Serialclk;
   always @(posedge Serialclk) cyc <= cyc + 1;

   // event log: every ParValid word and every Locked transition, sampled mid-cycle
   always @(negedge Serialclk) begin
      if (bus.ParValid === 1'b1) begin
         ev_word.push_back(bus.Parout);
         ev_comma.push_back(bus.CommaDet);
         ev_lock.push_back(bus.Locked);
         ev_cyc.push_back(cyc);
      end
      if (bus.Locked === 1'b1 && lk_prev !== 1'b1) rise_cyc = cyc;
      if (bus.Locked === 1'b0 && lk_prev === 1'b1) begin
         fall_cyc = cyc;
         fall_cnt++;
      end
      lk_prev = bus.Locked;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string sec, input int i, input logic [9:0] w,
                         input logic c, input logic l);
      logic [31:0] ow, oc, ol;
      ow = 'x; oc = 'x; ol = 'x;
      if (i < ev_word.size()) begin
         ow = 32'(ev_word[i]);
         oc = 32'(ev_comma[i]);
         ol = 32'(ev_lock[i]);
      end
      chk($sformatf("%s.ev%0d.word", sec, i), ow, 32'(w));
      chk($sformatf("%s.ev%0d.comma", sec, i), oc, 32'(c));
      chk($sformatf("%s.ev%0d.locked", sec, i), ol, 32'(l));
   endtask

   task automatic chk_table(input string sec);
      chk({sec, ".count"}, ev_word.size(), xw.size());
      for (int i = 0; i < xw.size(); i++) chk_ev(sec, i, xw[i], xc[i], xl[i]);
   endtask

   function automatic logic [31:0] ev_at(input int i);
      return (i < ev_cyc.size()) ? ev_cyc[i] : 'x;
   endfunction

   // drive n bits of val LSB first; last_samp = posedge that samples the last one
   task automatic send_bits(input logic [9:0] val, input int n);
      logic [9:0] v;
      v = val;
      for (int i = 0; i < n; i++) begin
         @(negedge Serialclk);
         bus.SerialIn = v[0];
         v = v >> 1;
         last_samp = cyc + 1;
      end
   endtask

   task automatic send_word(input logic [9:0] w, output int unsigned s);
      send_bits(w, 10);
      s = last_samp;
   endtask

   // 20-bit block: 5 filler, comma 5 bits off the word grid, 5 filler
   task automatic send_skew(output int unsigned sc);
      send_bits(10'h015, 5);
      send_bits(K28_5_NEG, 10);
      sc = last_samp;
      send_bits(10'h015, 5);
   endtask

   task automatic drain();
      send_bits(10'h002, 2);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Serialclk);
      SerialRST    = 1'b1;
      bus.SerialIn = 1'($urandom);
      @(negedge Serialclk);
      bus.SerialIn = 1'($urandom);
      @(negedge Serialclk);
      bus.SerialIn = 1'($urandom);
      @(negedge Serialclk);
      SerialRST    = 1'b0;
      bus.SerialIn = 1'b0;
      ev_word.delete();
      ev_comma.delete();
      ev_lock.delete();
      ev_cyc.delete();
   endtask

   initial begin
      int unsigned s0, s1, s2, s3, sc, nf;
      bus.SerialIn = 1'b0;

      // reset
      do_reset();
      @(negedge Serialclk);
      #1;
      chk("rst.Parout", 32'(bus.Parout), 32'h0);
      chk("rst.ParValid", 32'(bus.ParValid), 32'h0);
      chk("rst.CommaDet", 32'(bus.CommaDet), 32'h0);
      chk("rst.Locked", 32'(bus.Locked), 32'h0);

      // lock acquisition
      do_reset();
      send_bits(10'h02A, 7);
      send_word(10'h17C, s0);
      send_word(10'h155, s1);
      send_word(10'h283, s2);
      drain();
      xw = '{10'h17C, 10'h155, 10'h283};
      xc = '{1'b1, 1'b0, 1'b1};
      xl = '{1'b0, 1'b0, 1'b1};
      chk_table("acq");
      chk("acq.t0", ev_at(0), s0 + 1);
      chk("acq.t1", ev_at(1), s1 + 1);
      chk("acq.t2", ev_at(2), s2 + 1);
      chk("acq.rise", rise_cyc, s2 + 1);

      // CONFIRM realign by 3 bits
      do_reset();
      send_word(10'h17C, s0);
      send_bits(10'h005, 3);
      send_word(10'h17C, s1);
      send_word(10'h155, s2);
      send_word(10'h283, s3);
      drain();
      xw = '{10'h17C, 10'h3E5, 10'h17C, 10'h155, 10'h283};
      xc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      xl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      chk_table("rea");
      chk("rea.t1", ev_at(1), s0 + 11);
      chk("rea.t2", ev_at(2), s1 + 1);
      chk("rea.t3", ev_at(3), s2 + 1);
      chk("rea.rise", rise_cyc, s3 + 1);

      // loss of lock after 4 misaligned commas, then re-acquire
      do_reset();
      send_word(10'h17C, s0);
      send_word(10'h283, s1);
      for (int k = 0; k < 4; k++) begin
         send_word(10'h155, s2);
         send_skew(sc);
      end
      send_word(10'h17C, s2);
      send_word(10'h283, s3);
      drain();
      xw = '{10'h17C, 10'h283,
             10'h155, 10'h395, 10'h2AB, 10'h155, 10'h395, 10'h2AB,
             10'h155, 10'h395, 10'h2AB, 10'h155, 10'h395,
             10'h17C, 10'h283};
      xc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      xl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      chk_table("loss");
      chk("loss.t12", ev_at(12), sc - 4);
      chk("loss.fall", fall_cyc, sc + 1);
      chk("loss.t13", ev_at(13), s2 + 1);
      chk("loss.rise", rise_cyc, s3 + 1);

      // aligned comma clears the misaligned-comma count
      do_reset();
      send_word(10'h17C, s0);
      send_word(10'h283, s1);
      nf = fall_cnt;
      for (int k = 0; k < 3; k++) begin
         send_word(10'h155, s2);
         send_skew(sc);
      end
      send_word(10'h17C, s2);
      for (int k = 0; k < 3; k++) begin
         send_word(10'h155, s2);
         send_skew(sc);
      end
      send_word(10'h155, s2);
      #1;
      chk("clr.locked", 32'(bus.Locked), 32'h1);
      chk("clr.nofall", fall_cnt, nf);
      send_skew(sc);
      drain();
      chk("clr.fall", fall_cyc, sc + 1);
      chk("clr.fallcnt", fall_cnt, nf + 1);

      // serializer loopback stream, LSB first
      do_reset();
      for (int r = 0; r < 2; r++) begin
         send_word(10'h17C, s0);
         send_word(10'h283, s0);
         send_word(10'h0AA, s0);
         send_word(10'h3C3, s0);
      end
      drain();
      xw = '{10'h17C, 10'h283, 10'h0AA, 10'h3C3, 10'h17C, 10'h283, 10'h0AA, 10'h3C3};
      xc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      xl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      chk_table("loop");
      for (int i = 1; i < 8; i++)
         chk($sformatf("loop.gap%0d", i), ev_at(i) - ev_at(i - 1), 32'd10);

      // reset in the same cycle as an aligned comma match
      do_reset();
      send_word(10'h17C, s0);
      send_word(10'h283, s1);
      send_word(10'h155, s2);
      send_word(10'h17C, s3);
      @(negedge Serialclk);
      SerialRST    = 1'b1;
      bus.SerialIn = 1'b0;
      @(negedge Serialclk);
      #1;
      chk("rstw.ParValid", 32'(bus.ParValid), 32'h0);
      chk("rstw.CommaDet", 32'(bus.CommaDet), 32'h0);
      chk("rstw.Locked", 32'(bus.Locked), 32'h0);
      chk("rstw.Parout", 32'(bus.Parout), 32'h0);
      chk("rstw.count", ev_word.size(), 32'd3);
      SerialRST = 1'b0;
      repeat (3) @(negedge Serialclk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
